// File: rtl/gray_run_ctrl_if.sv
// Host-side command/status bundle for gray_run_ctrl.
// The host drives run commands (master); the controller reports status (slave).
interface gray_run_ctrl_if #(
  parameter int unsigned STEP_W = 5
) ();
  logic              Start;
  logic [STEP_W-1:0] Steps;
  logic              Hold;
  logic              Abort;
  logic              Busy;
  logic              Done;
  logic              Aborted;
  logic              Error;
  logic [STEP_W-1:0] Wraps;
  logic [2:0]        FinalGray;

  modport master (
    output Start, Steps, Hold, Abort,
    input  Busy, Done, Aborted, Error, Wraps, FinalGray
  );

  modport slave (
    input  Start, Steps, Hold, Abort,
    output Busy, Done, Aborted, Error, Wraps, FinalGray
  );
endinterface

// File: rtl/gray_run_ctrl.sv
// Run sequencer for a 3-bit gray counter: clears it, issues a counted number of enable
// pulses, checks each step for a single-bit change and consistent overflow, reports results.
module gray_run_ctrl #(
  parameter int unsigned STEP_W = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  gray_run_ctrl_if.slave       host,
  input  logic [2:0]           CntValue,
  input  logic                 CntOverflow,
  output logic                 CntReset,
  output logic                 CntEn
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic [STEP_W-1:0] wraps_q, wraps_d;
  logic [2:0]        prev_q, prev_d;
  logic [2:0]        final_q, final_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              error_q, error_d;

  logic              check_en;
  logic              wrap_seen;
  logic [2:0]        diff;

  always_comb begin
    CntReset = (state_q == StClear);
    CntEn    = (state_q == StRun) & ~host.Hold & ~host.Abort;
  end

  assign host.Busy      = (state_q != StIdle);
  assign host.Done      = done_q;
  assign host.Aborted   = aborted_q;
  assign host.Error     = error_q;
  assign host.Wraps     = wraps_q;
  assign host.FinalGray = final_q;

  // The value checked is the one produced by the step issued in the previous cycle.
  assign check_en  = pend_q && ((state_q == StRun) || (state_q == StDone));
  assign diff      = CntValue ^ prev_q;
  assign wrap_seen = (prev_q == 3'b100) && (CntValue == 3'b000);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wraps_d     = wraps_q;
    prev_d      = prev_q;
    final_d     = final_q;
    pend_d      = pend_q;
    aborted_d   = aborted_q;
    error_d     = error_q;
    done_d      = 1'b0;

    if (check_en) begin
      prev_d = CntValue;
      if (!$onehot(diff)) begin
        error_d = 1'b1;
      end
      if (wrap_seen) begin
        if (wraps_q != '1) begin
          wraps_d = wraps_q + STEP_W'(1);
        end
        if (!CntOverflow) begin
          error_d = 1'b1;
        end
      end else if (CntOverflow && (wraps_q == '0)) begin
        error_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (host.Start) begin
          state_d     = StClear;
          remaining_d = host.Steps;
          error_d     = 1'b0;
          wraps_d     = '0;
          aborted_d   = 1'b0;
        end
      end
      StClear: begin
        prev_d = 3'b000;
        pend_d = 1'b0;
        if (host.Abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else if (remaining_q == '0) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        pend_d = CntEn;
        if (host.Abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else if (CntEn) begin
          remaining_d = remaining_q - STEP_W'(1);
          if (remaining_q == STEP_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        final_d = CntValue;
        done_d  = 1'b1;
        pend_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      wraps_q     <= '0;
      prev_q      <= 3'b000;
      final_q     <= 3'b000;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wraps_q     <= wraps_d;
      prev_q      <= prev_d;
      final_q     <= final_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Bench for gray_run_ctrl: drives runs against a behavioural gray counter and compares
// results with a run-level model (steps issued, latency, final gray value, wrap count).
module tb_gray_run_ctrl;
  localparam int unsigned STEP_W = 5;

  logic       Clk;
  logic       Reset;
  logic [2:0] CntValue;
  logic       CntOverflow;
  logic       CntReset;
  logic       CntEn;

  gray_run_ctrl_if #(.STEP_W(STEP_W)) bus ();

  gray_run_ctrl #(.STEP_W(STEP_W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .host        (bus),
    .CntValue    (CntValue),
    .CntOverflow (CntOverflow),
    .CntReset    (CntReset),
    .CntEn       (CntEn)
  );

  int tests  = 0;
  int failed = 0;
  bit fault  = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural counter: binary count shown as gray; optional fault skips 001 -> 010.
  logic [2:0] cnt_bin;
  always @(posedge Clk) begin
    if (Reset || CntReset) begin
      cnt_bin     <= 3'd0;
      CntOverflow <= 1'b0;
    end else if (CntEn) begin
      if (fault && cnt_bin == 3'd1) cnt_bin <= 3'd3;
      else                          cnt_bin <= cnt_bin + 3'd1;
      if (cnt_bin == 3'd7) CntOverflow <= 1'b1;
    end
  end
  assign CntValue = cnt_bin ^ (cnt_bin >> 1);

  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      tests++;
      if (CntEn && CntReset) begin
        failed++;
        $display("FAIL en_reset_excl: CntEn=%b CntReset=%b required not both 1", CntEn, CntReset);
      end
    end
  end

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] v;
    v = 3'(b % 8);
    return v ^ (v >> 1);
  endfunction

  // Run-level reference: walk RUN cycles, counting steps until Steps reached or Abort.
  task automatic model_run(input int n, input bit abort_clear, input int abort_at,
                           input logic [63:0] hold_mask, output int run_cycles,
                           output int steps, output bit aborted);
    run_cycles = 0;
    steps      = 0;
    aborted    = abort_clear;
    if (n == 0 || abort_clear) return;
    for (int i = 0; i < 200; i++) begin
      if (i == abort_at) begin
        aborted    = 1'b1;
        run_cycles = i + 1;
        return;
      end
      if (!(i < 64 && hold_mask[i])) begin
        steps++;
        if (steps == n) begin
          run_cycles = i + 1;
          return;
        end
      end
    end
  endtask

  task automatic do_run(input string name, input int n, input bit abort_clear,
                        input int abort_at, input logic [63:0] hold_mask,
                        input bit start_noise);
    int  run_cycles, steps, en_count, b, exp_wraps;
    bit  exp_aborted, exp_error;
    model_run(n, abort_clear, abort_at, hold_mask, run_cycles, steps, exp_aborted);
    b         = steps + ((fault && steps >= 2) ? 1 : 0);
    exp_error = fault && steps >= 2;
    exp_wraps = b / 8;
    en_count  = 0;

    bus.Start = 1'b1;
    bus.Steps = STEP_W'(n);
    bus.Hold  = 1'b0;
    bus.Abort = 1'b0;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    bus.Steps = STEP_W'($urandom);
    bus.Abort = abort_clear;
    bus.Hold  = 1'($urandom);
    @(negedge Clk);
    tests++;
    if (CntReset !== 1'b1 || bus.Busy !== 1'b1 || CntEn !== 1'b0) begin
      failed++;
      $display("FAIL %s clear_cycle: CntReset=%b Busy=%b CntEn=%b required 1 1 0",
               name, CntReset, bus.Busy, CntEn);
    end
    tests++;
    if (bus.Error !== 1'b0 || bus.Wraps !== '0 || bus.Aborted !== 1'b0) begin
      failed++;
      $display("FAIL %s start_clears: Error=%b Wraps=%0d Aborted=%b required 0 0 0",
               name, bus.Error, bus.Wraps, bus.Aborted);
    end
    @(posedge Clk); #1;

    for (int i = 0; i < run_cycles; i++) begin
      bus.Hold  = (i < 64) ? hold_mask[i] : 1'b0;
      bus.Abort = (i == abort_at);
      bus.Start = start_noise && ($urandom_range(0, 1) == 1);
      bus.Steps = STEP_W'($urandom);
      @(negedge Clk);
      if (CntEn === 1'b1) en_count++;
      tests++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b1) begin
        failed++;
        $display("FAIL %s run_cycle%0d: Done=%b Busy=%b required 0 1",
                 name, i, bus.Done, bus.Busy);
      end
      @(posedge Clk); #1;
    end

    bus.Hold  = 1'b0;
    bus.Abort = 1'b0;
    bus.Start = 1'b0;
    @(negedge Clk);
    tests++;
    if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || CntEn !== 1'b0 || CntReset !== 1'b0) begin
      failed++;
      $display("FAIL %s done_state: Busy=%b Done=%b CntEn=%b CntReset=%b required 1 0 0 0",
               name, bus.Busy, bus.Done, CntEn, CntReset);
    end
    @(posedge Clk); #1;

    @(negedge Clk);
    tests++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
      failed++;
      $display("FAIL %s done_pulse: Done=%b Busy=%b required 1 0", name, bus.Done, bus.Busy);
    end
    tests++;
    if (en_count != steps) begin
      failed++;
      $display("FAIL %s en_count: got %0d required %0d", name, en_count, steps);
    end
    tests++;
    if (bus.FinalGray !== to_gray(b)) begin
      failed++;
      $display("FAIL %s final_gray: got %b required %b", name, bus.FinalGray, to_gray(b));
    end
    tests++;
    if (bus.Wraps !== STEP_W'(exp_wraps)) begin
      failed++;
      $display("FAIL %s wraps: got %0d required %0d", name, bus.Wraps, exp_wraps);
    end
    tests++;
    if (bus.Error !== exp_error || bus.Aborted !== exp_aborted) begin
      failed++;
      $display("FAIL %s flags: Error=%b Aborted=%b required %b %b",
               name, bus.Error, bus.Aborted, exp_error, exp_aborted);
    end
  endtask

  task automatic check_done_low(input string name);
    @(posedge Clk); #1;
    @(negedge Clk);
    tests++;
    if (bus.Done !== 1'b0) begin
      failed++;
      $display("FAIL %s done_single: Done=%b required 0", name, bus.Done);
    end
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Steps = '0;
    bus.Hold  = 1'b0;
    bus.Abort = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    tests++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Aborted !== 1'b0 ||
        bus.Error !== 1'b0 || bus.Wraps !== '0 || bus.FinalGray !== 3'b000 ||
        CntEn !== 1'b0 || CntReset !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: Busy=%b Done=%b Ab=%b Err=%b Wraps=%0d FG=%b En=%b CR=%b %s",
               bus.Busy, bus.Done, bus.Aborted, bus.Error, bus.Wraps, bus.FinalGray,
               CntEn, CntReset, "required all 0");
    end
  endtask

  task automatic test_basic();
    do_run("basic3", 3, 1'b0, -1, 64'd0, 1'b0);
    check_done_low("basic3");
  endtask

  task automatic test_wrap();
    do_run("wrap8", 8, 1'b0, -1, 64'd0, 1'b0);
    tests++;
    if (CntOverflow !== 1'b1) begin
      failed++;
      $display("FAIL wrap8 overflow: got %b required 1", CntOverflow);
    end
    check_done_low("wrap8");
  endtask

  task automatic test_hold();
    do_run("hold5", 5, 1'b0, -1, 64'b1100, 1'b0);
    check_done_low("hold5");
  endtask

  task automatic test_back_to_back();
    do_run("abort20", 20, 1'b0, 3, 64'd0, 1'b0);
    do_run("b2b_after_abort", 6, 1'b0, -1, 64'd0, 1'b0);
    check_done_low("b2b_after_abort");
  endtask

  task automatic test_zero_and_ignored_start();
    do_run("zero", 0, 1'b0, -1, 64'd0, 1'b0);
    check_done_low("zero");
    do_run("abort_clear", 7, 1'b1, -1, 64'd0, 1'b0);
    check_done_low("abort_clear");
    do_run("start_noise", 12, 1'b0, -1, 64'b101000, 1'b1);
    check_done_low("start_noise");
  endtask

  task automatic test_fault();
    fault = 1'b1;
    do_run("fault", 5, 1'b0, -1, 64'd0, 1'b0);
    fault = 1'b0;
    do_run("after_fault", 4, 1'b0, -1, 64'd0, 1'b0);
    check_done_low("after_fault");
  endtask

  task automatic test_reset_midrun();
    bus.Start = 1'b1;
    bus.Steps = STEP_W'(20);
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    repeat (4) begin
      @(posedge Clk); #1;
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    tests++;
    if (bus.Busy !== 1'b0 || CntValue !== 3'b000 || CntEn !== 1'b0) begin
      failed++;
      $display("FAIL reset_midrun: Busy=%b CntValue=%b CntEn=%b required 0 000 0",
               bus.Busy, CntValue, CntEn);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      tests++;
      if (bus.Done !== 1'b0) begin
        failed++;
        $display("FAIL reset_midrun no_done%0d: Done=%b required 0", i, bus.Done);
      end
    end
    do_run("after_reset", 9, 1'b0, -1, 64'd0, 1'b0);
    check_done_low("after_reset");
  endtask

  task automatic test_random();
    logic [63:0] mask;
    int          n, abort_at;
    bit          abort_clear;
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 31);
      for (int i = 0; i < 64; i++) mask[i] = ($urandom_range(0, 9) < 3);
      abort_at    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1;
      abort_clear = ($urandom_range(0, 9) == 0);
      do_run($sformatf("rand%0d", r), n, abort_clear, abort_at, mask,
             $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) check_done_low($sformatf("rand%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_zero_and_ignored_start();
    test_fault();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
